ifu_fetch: RTL and testbench

- Instruction fetch unit that sits directly upstream of the combinational instruction ROM.
- Owns the PC and drives the ROM address.
- Captures the returned instruction word into a small in-order buffer and presents {pc, inst} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing and restarting fetch, and traps misaligned redirect targets.

---
 rtl/ifu_fetch.sv | 154 +++++++++++++++
 tb/tb_ifu_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
`timescale 1ns/1ps
// ifu_fetch: instruction fetch unit sitting directly in front of a
// combinational instruction ROM. It owns the PC, drives the ROM address,
// captures returned words into a small in-order buffer and hands
// {pc, inst} to decode over a valid/ready handshake. Redirects from execute
// flush the buffer and restart fetch; misaligned redirect targets park the
// unit in a FAULT state until a good redirect arrives.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - asynchronous active-high reset
//   imem_addr      - ROM byte address (always the current PC, word aligned)
//   imem_rdata     - ROM data for imem_addr, valid in the same cycle
//   redirect_valid - next-PC override from execute
//   redirect_pc    - redirect target
//   out_valid      - buffer head is valid
//   out_ready      - decode accepts the head this cycle
//   out_pc         - PC of the head entry
//   out_inst       - instruction word of the head entry
//   fault          - misaligned-redirect fault is latched
//   fault_pc       - the offending redirect target
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]      pc_q;
  logic [31:0]      fault_pc_q;
  logic [31:0]      buf_pc   [BUF_DEPTH];
  logic [31:0]      buf_inst [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic redirect_take;
  logic redirect_ok;
  logic push;
  logic pop;

  // Redirects are ignored during the single BOOT cycle. A taken redirect
  // wins over everything else: no fetch, and any same-cycle pop is dropped
  // because the whole buffer is flushed anyway. A full buffer may still
  // accept a fetch when the head is being popped in the same cycle, which
  // is what gives one instruction per cycle in steady state.
  always_comb begin
    redirect_take = redirect_valid && (state_q != S_BOOT);
    redirect_ok   = redirect_take && (redirect_pc[1:0] == 2'b00);
    pop           = out_valid && out_ready;
    push          = (state_q == S_RUN) && !redirect_take &&
                    ((count < FULL_CNT) || pop);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: BOOT always moves on to RUN after one idle cycle;
  // from RUN or FAULT, an aligned redirect (re)starts fetch and a
  // misaligned one parks the unit in FAULT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      default: begin
        if (redirect_take) begin
          state_d = redirect_ok ? S_RUN : S_FAULT;
        end
      end
    endcase
  end

  // Output logic. The head fields read the buffer slot directly, so they
  // keep showing the stale slot once the buffer drains.
  always_comb begin
    imem_addr = pc_q;
    out_valid = (count != '0);
    out_pc    = buf_pc[rd_ptr];
    out_inst  = buf_inst[rd_ptr];
    fault     = (state_q == S_FAULT);
    fault_pc  = fault_pc_q;
  end

  // PC, fetch buffer and fault target. A flush resets both pointers as well
  // as the count so the restarted stream always begins in slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else if (redirect_take) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirect_ok) begin
        pc_q <= redirect_pc;
      end else begin
        fault_pc_q <= redirect_pc;
      end
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= pc_q;
        buf_inst[wr_ptr] <= imem_rdata;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        pc_q             <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
// Self-checking bench for ifu_fetch. A combinational ROM model returns the
// word index relative to 0x8000_0000, so the expected instruction for any
// PC follows directly from that PC. Each table row describes one clock
// cycle: inputs driven in that cycle and the outputs expected before the
// closing clock edge. A row may request a fresh reset before it is applied.
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        fault;
  logic [31:0] fault_pc;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rst_before;
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        efault;
    logic [31:0] efpc;
  } vec_t;

  vec_t vecs[$];

  ifu_fetch #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // ROM model: word i above 0x8000_0000 holds the value i.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr - 32'h8000_0000) >> 2;
  endfunction

  assign imem_rdata = rom_word(imem_addr);

  function automatic vec_t mk(input logic rb, input logic rv, input logic [31:0] rpc,
                              input logic ready, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr, input logic efault,
                              input logic [31:0] efpc);
    vec_t v;
    v.rst_before = rb;
    v.rv         = rv;
    v.rpc        = rpc;
    v.ready      = ready;
    v.ev         = ev;
    v.epc        = epc;
    v.eaddr      = eaddr;
    v.efault     = efault;
    v.efpc       = efpc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    out_ready      = v.ready;
  endtask

  // Asserts reset away from the clock edge, checks the reset values before
  // any edge arrives, then releases reset shortly after a rising edge so
  // the next negedge falls in the BOOT cycle.
  task automatic doReset(input int idx);
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    checkOutput("reset out_valid", idx, {31'b0, out_valid}, 32'd0);
    checkOutput("reset imem_addr", idx, imem_addr, RESET_PC);
    checkOutput("reset out_pc", idx, out_pc, 32'd0);
    checkOutput("reset out_inst", idx, out_inst, 32'd0);
    checkOutput("reset fault", idx, {31'b0, fault}, 32'd0);
    checkOutput("reset fault_pc", idx, fault_pc, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Plain streaming after reset: one BOOT cycle, one fetch cycle, then
    // one instruction per cycle.
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,            32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0000, 32'h8000_0004, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0004, 32'h8000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0008, 32'h8000_000C, 0, 0));

    // Redirect during BOOT must be ignored.
    vecs.push_back(mk(1, 1, 32'h8000_0200, 1, 0, 0, 32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0,             1, 0, 0, 32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0000, 32'h8000_0004, 0, 0));

    // Backpressure: buffer fills to two entries and the head stays put.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,            32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,            32'h8000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0004, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0000, 32'h8000_0008, 0, 0));
    // Release: full buffer pops and refills in the same cycle.
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0000, 32'h8000_0008, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0004, 32'h8000_000C, 0, 0));
    // Redirect while full with out_ready=1: the pop is discarded.
    vecs.push_back(mk(0, 1, 32'h8000_0040, 1, 1, 32'h8000_0008, 32'h8000_0010, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            32'h8000_0040, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0040, 32'h8000_0044, 0, 0));
    // Misaligned redirect: fault latched, PC held, nothing valid.
    vecs.push_back(mk(0, 1, 32'h8000_0042, 1, 1, 32'h8000_0044, 32'h8000_0048, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h8000_0048, 1, 32'h8000_0042));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h8000_0048, 1, 32'h8000_0042));
    // Aligned redirect out of FAULT resumes fetch at the target.
    vecs.push_back(mk(0, 1, 32'h8000_0100, 1, 0, 0, 32'h8000_0048, 1, 32'h8000_0042));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            32'h8000_0100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8000_0100, 32'h8000_0104, 0, 0));
    // Redirect to the top of the address space: PC wraps to zero.
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h8000_0104, 32'h8000_0108, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,            32'hFFFF_FFFC, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_0000, 32'h0000_0004, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) begin
        doReset(i);
      end
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("out_valid", i, {31'b0, out_valid}, {31'b0, vecs[i].ev});
      checkOutput("imem_addr", i, imem_addr, vecs[i].eaddr);
      checkOutput("fault", i, {31'b0, fault}, {31'b0, vecs[i].efault});
      if (vecs[i].efault) begin
        checkOutput("fault_pc", i, fault_pc, vecs[i].efpc);
      end
      if (vecs[i].ev) begin
        checkOutput("out_pc", i, out_pc, vecs[i].epc);
        checkOutput("out_inst", i, out_inst, rom_word(vecs[i].epc));
      end
    end

    // Reset asserted mid-stream while out_valid=1: outputs must return to
    // reset values before the next rising edge.
    #1;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    #1;
    checkOutput("async out_valid", 100, {31'b0, out_valid}, 32'd0);
    checkOutput("async imem_addr", 100, imem_addr, RESET_PC);
    checkOutput("async out_pc", 100, out_pc, 32'd0);
    checkOutput("async fault", 100, {31'b0, fault}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post-reset boot valid", 101, {31'b0, out_valid}, 32'd0);
    checkOutput("post-reset boot addr", 101, imem_addr, RESET_PC);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
